frame_parse_sequencer: RTL and testbench
========================================

Name: frame_parse_sequencer

Overview:
Top-level sequencer for the receive frame parser. It walks an incoming byte stream through the fixed field order PREAMBLE, SFD, DEST, SRC, LEN, PAYLOAD_CRC. It validates the preamble and SFD bytes, counts the address and length bytes, and holds the payload/CRC parser's enable for the payload phase. It then waits for that parser's size-valid pulse and reports a frame-done or frame-error pulse plus running counts.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD
PREAMBLE_BYTE, 8'h55, required preamble value
SFD_BYTE, 8'hD5, required start-frame-delimiter value
ADDR_LEN, 6, bytes per destination and per source address field
LEN_LEN, 2, bytes in the length field
PLD_TIMEOUT, 64, maximum cycles in PAYLOAD_CRC waiting for pld_size_valid
CNT_W, 4, width of the frame and error counters

Ports:
clock  in  1  rising-edge clock
reset  in  1  reset, synchronous, active-high
byte_valid  in  1  byte_data is valid this cycle
byte_data  in  8  received byte
pld_size_valid  in  1  one-cycle done pulse from the payload/CRC parser
payload_enable  out  1  enable to the payload/CRC parser
field_sel  out  3  current field: 0 IDLE, 1 PRE, 2 SFD, 3 DEST, 4 SRC, 5 LEN, 6 PLD, 7 ERR
busy  out  1  high in any state except IDLE
frame_done  out  1  one-cycle pulse when a frame completes
frame_error  out  1  one-cycle pulse when a frame aborts
frame_count  out  CNT_W  completed frames, wraps modulo 2^CNT_W

Behaviour:
- All outputs are registered. After reset: state IDLE, all pulses 0, payload_enable 0, field_sel 0, frame_count 0, internal byte counter 0, timeout counter 0.
- Byte counter advances only on cycles with byte_valid=1; gaps hold all counters and the current state.
- IDLE: on byte_valid with byte_data==PREAMBLE_BYTE, count=1 and go to PRE. Any other byte stays in IDLE silently.
- PRE: each valid byte must equal PREAMBLE_BYTE. On the PREAMBLE_LEN-th matching byte, go to SFD. A mismatch goes to ERR.
- SFD: the next valid byte must equal SFD_BYTE, then go to DEST with count=0. Otherwise go to ERR.
- DEST, SRC: accept ADDR_LEN valid bytes each, with no content check. After the last byte, advance with count cleared.
- LEN: accept LEN_LEN bytes, then go to PLD.
- PLD: payload_enable=1 for the whole state, starting the cycle after the last LEN byte is accepted. Timeout counter increments every cycle.
  - pld_size_valid=1: next cycle is IDLE, frame_done=1 for one cycle, frame_count+1. payload_enable drops the same cycle.
  - Timeout reaches PLD_TIMEOUT before pld_size_valid: go to ERR.
  - pld_size_valid and timeout in the same cycle: completion wins.
- pld_size_valid outside PLD is ignored.
- ERR: frame_error=1 for exactly one cycle, payload_enable=0, then IDLE. Bytes received during ERR are dropped and are not rechecked for preamble.
- frame_count wraps from 2^CNT_W-1 to 0 with no saturation.
- Reset mid-frame: state returns to IDLE the next cycle, no pulse is emitted, and counters clear.
- Throughput: back-to-back frames are allowed. A preamble byte arriving on the frame_done cycle is not captured; the first capturable byte is one cycle later.

Optional Feature:
Macro FRAME_SEQ_ERR_CNT_EN.
- Defined: adds output err_count[CNT_W-1:0] and input err_clear. err_count increments on every frame_error pulse and saturates at all-ones. err_clear zeroes it synchronously and has priority over an increment in the same cycle. Reset value 0.
- Undefined: neither port exists and no error-counter logic is synthesized.

Decomposition:
- Shared package (frame_parse_pkg): state/field_sel encoding constants (IDLE..ERR), the PREAMBLE_BYTE and SFD_BYTE defaults, and the default field lengths. The existing field parsers reuse these.
- One sub-module is natural: field_byte_counter. It is a loadable counter with a terminal-count flag, a byte_valid qualifier and a clear, shared by the PRE, DEST, SRC and LEN stages.

Test Plan:
- Good frame: 7x0x55, 0xD5, 14 arbitrary bytes, then pld_size_valid pulsed 50 cycles into PLD -> payload_enable high exactly in PLD; frame_done pulses once; frame_count 0->1; frame_error never asserts.
- Bad preamble: 0x55 x3 then 0x54 -> state ERR; frame_error pulses once; IDLE next cycle; frame_count unchanged.
- Bad SFD: 7x0x55 then 0xD4 -> frame_error pulse; payload_enable never asserts.
- Timeout: good header, no pld_size_valid for 64 cycles -> frame_error pulse; payload_enable deasserts; pld_size_valid=1 on the timeout cycle instead gives frame_done.
- Gaps and wrap: good frames with byte_valid toggling 1/0 -> same results; 16 good frames -> frame_count wraps 15->0.
- Reset in PLD after 20 cycles -> IDLE next cycle; no pulses; frame_count 0. With FRAME_SEQ_ERR_CNT_EN defined, 3 errors -> err_count=3; err_clear -> 0.

Source files
------------

// File: rtl/frame_parse_pkg.sv
// Shared encodings and default field geometry for the receive frame parser blocks.
package frame_parse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DEST = 3'd3,
    ST_SRC  = 3'd4,
    ST_LEN  = 3'd5,
    ST_PLD  = 3'd6,
    ST_ERR  = 3'd7
  } field_e;

  localparam logic [7:0]  PREAMBLE_BYTE_DEF = 8'h55;
  localparam logic [7:0]  SFD_BYTE_DEF      = 8'hD5;
  localparam int unsigned PREAMBLE_LEN_DEF  = 7;
  localparam int unsigned ADDR_LEN_DEF      = 6;
  localparam int unsigned LEN_LEN_DEF       = 2;
  localparam int unsigned PLD_TIMEOUT_DEF   = 64;
  localparam int unsigned CNT_W_DEF         = 4;

  // Wide enough for any field length used by the parsers.
  localparam int unsigned BYTE_CNT_W = 8;

  // Count value held while the last byte of a field of length len is accepted.
  function automatic logic [BYTE_CNT_W-1:0] last_index(input int unsigned len);
    return BYTE_CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/frame_parse_sequencer_field_byte_counter.sv
// Loadable byte counter with a terminal-count flag, shared by the header field stages.
module field_byte_counter
  import frame_parse_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [BYTE_CNT_W-1:0] load_value,
  input  logic [BYTE_CNT_W-1:0] last_value,
  input  logic                  byte_valid,
  output logic                  at_last_c
);

  logic [BYTE_CNT_W-1:0] count;

  // Clear beats load beats step; idle cycles hold the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (byte_valid) begin
      count <= count + BYTE_CNT_W'(1);
    end
  end

  assign at_last_c = (count == last_value);

endmodule

// File: rtl/frame_parse_sequencer.sv
// Receive frame sequencer: walks PREAMBLE, SFD, DEST, SRC, LEN, PAYLOAD_CRC and reports done/error.
// Optional error counter (err_count/err_clear) is built when FRAME_SEQ_ERR_CNT_EN is defined.
module frame_parse_sequencer
  import frame_parse_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN  = PREAMBLE_LEN_DEF,
  parameter logic [7:0]  PREAMBLE_BYTE = PREAMBLE_BYTE_DEF,
  parameter logic [7:0]  SFD_BYTE      = SFD_BYTE_DEF,
  parameter int unsigned ADDR_LEN      = ADDR_LEN_DEF,
  parameter int unsigned LEN_LEN       = LEN_LEN_DEF,
  parameter int unsigned PLD_TIMEOUT   = PLD_TIMEOUT_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             pld_size_valid,
`ifdef FRAME_SEQ_ERR_CNT_EN
  input  logic             err_clear,
  output logic [CNT_W-1:0] err_count,
`endif
  output logic             payload_enable,
  output logic [2:0]       field_sel,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_error,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned TMO_W = $clog2(PLD_TIMEOUT + 1);

  field_e                state;
  logic [TMO_W-1:0]      tmo_count;
  logic                  pre_hit;
  logic                  sfd_hit;
  logic                  cnt_last;
  logic                  cnt_clear;
  logic                  cnt_load;
  logic                  cnt_step;
  logic [BYTE_CNT_W-1:0] last_value;

  assign pre_hit   = (byte_data == PREAMBLE_BYTE);
  assign sfd_hit   = (byte_data == SFD_BYTE);
  assign field_sel = state;

  // Byte counter control: terminal value per field, step only on accepted bytes.
  always_comb begin
    cnt_clear  = 1'b0;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    last_value = '0;
    case (state)
      ST_PRE:          last_value = last_index(PREAMBLE_LEN);
      ST_DEST, ST_SRC: last_value = last_index(ADDR_LEN);
      ST_LEN:          last_value = last_index(LEN_LEN);
      default:         last_value = '0;
    endcase
    if (byte_valid) begin
      case (state)
        ST_IDLE: cnt_load = pre_hit && !frame_done;
        ST_PRE: begin
          cnt_clear = !pre_hit || cnt_last;
          cnt_step  = pre_hit && !cnt_last;
        end
        ST_DEST, ST_SRC, ST_LEN: begin
          cnt_clear = cnt_last;
          cnt_step  = !cnt_last;
        end
        default: cnt_clear = 1'b1;
      endcase
    end
  end

  field_byte_counter u_byte_counter (
    .clock      (clock),
    .reset      (reset),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .load_value (BYTE_CNT_W'(1)),
    .last_value (last_value),
    .byte_valid (cnt_step),
    .at_last_c  (cnt_last)
  );

  // Sequencer state with registered status outputs updated on each transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      payload_enable <= 1'b0;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;
      frame_count    <= '0;
      tmo_count      <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The frame_done cycle cannot start a new frame.
          if (byte_valid && pre_hit && !frame_done) begin
            state <= ST_PRE;
            busy  <= 1'b1;
          end
        end
        ST_PRE: begin
          if (byte_valid) begin
            if (!pre_hit) begin
              state       <= ST_ERR;
              frame_error <= 1'b1;
            end else if (cnt_last) begin
              state <= ST_SFD;
            end
          end
        end
        ST_SFD: begin
          if (byte_valid) begin
            if (sfd_hit) begin
              state <= ST_DEST;
            end else begin
              state       <= ST_ERR;
              frame_error <= 1'b1;
            end
          end
        end
        ST_DEST: begin
          if (byte_valid && cnt_last) begin
            state <= ST_SRC;
          end
        end
        ST_SRC: begin
          if (byte_valid && cnt_last) begin
            state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (byte_valid && cnt_last) begin
            state          <= ST_PLD;
            payload_enable <= 1'b1;
            tmo_count      <= '0;
          end
        end
        ST_PLD: begin
          // Completion wins over a coincident timeout.
          if (pld_size_valid) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            payload_enable <= 1'b0;
            frame_done     <= 1'b1;
            frame_count    <= frame_count + CNT_W'(1);
            tmo_count      <= '0;
          end else if (tmo_count == TMO_W'(PLD_TIMEOUT - 1)) begin
            state          <= ST_ERR;
            payload_enable <= 1'b0;
            frame_error    <= 1'b1;
            tmo_count      <= '0;
          end else begin
            tmo_count <= tmo_count + TMO_W'(1);
          end
        end
        ST_ERR: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_SEQ_ERR_CNT_EN
  // Saturating abort counter; clear has priority over a coincident increment.
  always_ff @(posedge clock) begin
    if (reset || err_clear) begin
      err_count <= '0;
    end else if (frame_error && !(&err_count)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_frame_parse_sequencer.sv
// Randomized bench for frame_parse_sequencer against a byte-position reference model.
module tb_frame_parse_sequencer;

  localparam int unsigned CNT_MOD = 16;
  localparam int unsigned HDR_LEN = 22;

  logic       clock = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       pld_size_valid;
  logic       payload_enable;
  logic [2:0] field_sel;
  logic       busy;
  logic       frame_done;
  logic       frame_error;
  logic [3:0] frame_count;
`ifdef FRAME_SEQ_ERR_CNT_EN
  logic       err_clear;
  logic [3:0] err_count;
  logic       clr_drive = 1'b0;
`endif

  always #5 clock = ~clock;

  frame_parse_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .pld_size_valid (pld_size_valid),
`ifdef FRAME_SEQ_ERR_CNT_EN
    .err_clear      (err_clear),
    .err_count      (err_count),
`endif
    .payload_enable (payload_enable),
    .field_sel      (field_sel),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .frame_count    (frame_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 = header (m_pos bytes accepted so far), 1 = payload wait, 2 = abort.
  int m_phase, m_pos, m_tcnt, m_fcount, m_errs;
  bit m_done, m_err;

  function automatic int exp_field();
    if (m_phase == 2) return 7;
    if (m_phase == 1) return 6;
    if (m_pos == 0) return 0;
    if (m_pos < 7) return 1;
    if (m_pos == 7) return 2;
    if (m_pos < 14) return 3;
    if (m_pos < 20) return 4;
    return 5;
  endfunction

  task automatic model_step(input bit rst, input bit bv, input logic [7:0] bd, input bit psv, input bit clr);
    bit prev_done;
    if (rst) begin
      m_phase = 0; m_pos = 0; m_tcnt = 0; m_fcount = 0; m_errs = 0;
      m_done = 0; m_err = 0;
      return;
    end
    if (clr) m_errs = 0;
    else if (m_err && m_errs < CNT_MOD - 1) m_errs++;
    prev_done = m_done;
    m_done = 0;
    m_err  = 0;
    case (m_phase)
      2: begin m_phase = 0; m_pos = 0; end
      1: begin
        if (psv) begin
          m_done = 1; m_fcount = (m_fcount + 1) % CNT_MOD; m_phase = 0; m_pos = 0;
        end else if (m_tcnt + 1 >= 64) begin
          m_err = 1; m_phase = 2; m_pos = 0;
        end else begin
          m_tcnt++;
        end
      end
      default: begin
        if (bv) begin
          if (m_pos == 0) begin
            if (bd == 8'h55 && !prev_done) m_pos = 1;
          end else if (m_pos < 8 && bd != ((m_pos < 7) ? 8'h55 : 8'hD5)) begin
            m_err = 1; m_phase = 2; m_pos = 0;
          end else begin
            m_pos++;
            if (m_pos == HDR_LEN) begin m_phase = 1; m_tcnt = 0; end
          end
        end
      end
    endcase
  endtask

  // One clock: compare outputs mid-cycle, drive new inputs, advance the model on the edge.
  task automatic tick(input logic rst, input logic bv, input logic [7:0] bd, input logic psv);
    bit clr;
    @(negedge clock);
    check("field_sel", 32'(field_sel), 32'(exp_field()));
    check("busy", 32'(busy), 32'(!(m_phase == 0 && m_pos == 0)));
    check("payload_enable", 32'(payload_enable), 32'(m_phase == 1));
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("frame_error", 32'(frame_error), 32'(m_err));
    check("frame_count", 32'(frame_count), 32'(m_fcount));
    clr = 1'b0;
`ifdef FRAME_SEQ_ERR_CNT_EN
    check("err_count", 32'(err_count), 32'(m_errs));
    err_clear = clr_drive;
    clr = clr_drive;
`endif
    reset = rst; byte_valid = bv; byte_data = bd; pld_size_valid = psv;
    @(posedge clock);
    model_step(rst, bv, bd, psv, clr);
  endtask

  function automatic logic [7:0] noise();
    logic [7:0] v;
    v = 8'($urandom);
    if (v == 8'h55) v = 8'h00;
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, $urandom_range(3) == 0, noise(), $urandom_range(7) == 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int n;
    n = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 2) : 0;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, noise(), $urandom_range(5) == 0);
    tick(1'b0, 1'b1, b, 1'b0);
  endtask

  // kind 0 good, 1 bad preamble at bad_idx, 2 bad SFD; rst_at < pld_wait resets inside payload.
  task automatic send_frame(input int kind, input int bad_idx, input int gap_pct,
                            input int pld_wait, input int rst_at);
    logic [7:0] b;
    for (int i = 0; i < HDR_LEN; i++) begin
      if (i < 7) b = 8'h55;
      else if (i == 7) b = 8'hD5;
      else b = 8'($urandom);
      if (kind == 1 && i == bad_idx) b = 8'h55 ^ 8'($urandom_range(1, 255));
      if (kind == 2 && i == 7) b = 8'hD5 ^ 8'($urandom_range(1, 255));
      send_byte(b, gap_pct);
      if ((kind == 1 && i == bad_idx) || (kind == 2 && i == 7)) break;
    end
    if (kind == 0) begin
      for (int k = 0; k <= pld_wait; k++) begin
        if (k == rst_at) begin
          tick(1'b1, 1'b0, 8'h00, 1'b0);
          break;
        end
        tick(1'b0, $urandom_range(1) == 1, noise(), k == pld_wait);
      end
    end
  endtask

  initial begin
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; pld_size_valid = 1'b0;
`ifdef FRAME_SEQ_ERR_CNT_EN
    err_clear = 1'b0;
`endif
    repeat (2) @(posedge clock);
    model_step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    idle(3);
    send_frame(0, 0, 0, 49, -1);   idle(3);
    send_frame(1, 3, 0, 0, -1);    idle(3);
    send_frame(2, 0, 0, 0, -1);    idle(3);
    send_frame(0, 0, 0, 70, -1);   idle(3);
    send_frame(0, 0, 0, 63, -1);   idle(3);
    send_frame(0, 0, 0, 62, -1);   idle(3);
    for (int f = 0; f < 4; f++) begin
      send_frame(0, 0, 50, $urandom_range(0, 10), -1);
      idle(2);
    end
    for (int f = 0; f < 17; f++) begin
      send_frame(0, 0, 0, $urandom_range(0, 3), -1);
      idle(1);
    end
    send_frame(0, 0, 0, 40, 20);   idle(3);
    send_frame(0, 0, 0, 2, -1);    send_frame(0, 0, 0, 2, -1);  idle(3);
`ifdef FRAME_SEQ_ERR_CNT_EN
    clr_drive = 1'b1; tick(1'b0, 1'b0, 8'h00, 1'b0); clr_drive = 1'b0;
    for (int f = 0; f < 3; f++) begin
      send_frame(1, $urandom_range(1, 6), 0, 0, -1);
      idle(3);
    end
    clr_drive = 1'b1; tick(1'b0, 1'b0, 8'h00, 1'b0); clr_drive = 1'b0;
    idle(2);
`endif
    for (int f = 0; f < 150; f++) begin
      int kind;
      int wait_c;
      kind   = ($urandom_range(3) == 0) ? $urandom_range(1, 2) : 0;
      wait_c = ($urandom_range(3) == 0) ? $urandom_range(55, 70) : $urandom_range(0, 10);
      send_frame(kind, $urandom_range(1, 6), $urandom_range(0, 40), wait_c,
                 ($urandom_range(19) == 0) ? $urandom_range(0, 5) : -1);
      idle($urandom_range(0, 3));
    end
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
